seq_match_det: RTL and testbench

Parametrised streaming pattern detector: watches a stream of W-bit symbols and flags every occurrence of a runtime-loadable N-symbol pattern. Outputs are a same-cycle Mealy flag, a registered Moore flag and a saturating match counter. It is the generalised successor of the team's two-input (x, y) sequence-detector FSMs and sits directly on an input symbol stream in the assignment-level designs.

---
 rtl/seq_match_det.sv | 106 ++++++++++
 tb/tb_seq_match_det.sv | 161 ++++++++++++++++
 2 files changed

// File: rtl/seq_match_det.sv
`default_nettype none
// ============================================================================
// Module   : seq_match_det
// Purpose  : Streaming detector for a runtime-loadable N-symbol pattern with
//            Mealy/Moore match flags and a saturating match counter.
// Revision : 1.0 - initial release
// ============================================================================
module seq_match_det #(
  parameter int              W            = 2,
  parameter int              N            = 4,
  parameter int              CNT_W        = 8,
  parameter int              OVERLAP      = 1,
  parameter logic [N*W-1:0]  PATTERN_INIT = 8'b00_01_10_11
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               in_valid,
  input  logic [W-1:0]       in_sym,
  input  logic               cfg_load,
  input  logic [N*W-1:0]     cfg_pattern,
  output logic               z,
  output logic               o,
  output logic [CNT_W-1:0]   match_cnt
);

  localparam int             FILL_W     = (N > 1) ? $clog2(N) : 1;
  localparam logic [FILL_W-1:0] c_FILL_MAX = FILL_W'(N - 1);

  logic [N*W-1:0]    r_pattern;
  logic [FILL_W-1:0] r_fill;
  logic              r_o;
  logic [CNT_W-1:0]  r_cnt;

  logic              w_accept;
  logic              w_full;
  logic              w_match;
  logic [N*W-1:0]    w_window;

  assign w_accept = in_valid & ~cfg_load;
  assign w_full   = (r_fill == c_FILL_MAX);
  assign w_match  = w_accept & w_full & (w_window == r_pattern);

  // Window is the stored history (oldest in MSBs) followed by the live symbol.
  generate
    if (N > 1) begin : g_hist
      logic [(N-1)*W-1:0] r_hist;

      assign w_window = {r_hist, in_sym};

      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          r_hist <= '0;
        end else if (w_accept) begin
          r_hist <= w_window[(N-1)*W-1:0];
        end
      end
    end else begin : g_no_hist
      assign w_window = in_sym;
    end
  endgenerate

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_pattern <= PATTERN_INIT;
    end else if (cfg_load) begin
      r_pattern <= cfg_pattern;
    end
  end

  // Non-overlapping mode restarts the fill after each hit.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_fill <= '0;
    end else if (cfg_load) begin
      r_fill <= '0;
    end else if (w_accept) begin
      if (w_match && (OVERLAP == 0)) begin
        r_fill <= '0;
      end else if (r_fill != c_FILL_MAX) begin
        r_fill <= r_fill + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_o <= 1'b0;
    end else begin
      r_o <= w_match;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_cnt <= '0;
    end else if (w_match && (r_cnt != {CNT_W{1'b1}})) begin
      r_cnt <= r_cnt + 1'b1;
    end
  end

  assign z         = w_match;
  assign o         = r_o;
  assign match_cnt = r_cnt;

endmodule
`default_nettype wire

// File: tb/tb_seq_match_det.sv
`default_nettype none
// ============================================================================
// Module   : tb_seq_match_det
// Purpose  : Directed scoreboard bench driving three detector variants
//            (overlap, non-overlap, 2-bit counter) with one shared stream.
// Revision : 1.0 - initial release
// ============================================================================
module tb_seq_match_det;

  logic       clk;
  logic       rst;
  logic       in_valid;
  logic [1:0] in_sym;
  logic       cfg_load;
  logic [7:0] cfg_pattern;

  logic       z0, z1, z2;
  logic       o0, o1, o2;
  logic [7:0] cnt0, cnt1;
  logic [1:0] cnt2;

  seq_match_det #(.W(2), .N(4), .CNT_W(8), .OVERLAP(1), .PATTERN_INIT(8'b00_01_10_11)) u_dut0 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_sym(in_sym), .cfg_load(cfg_load),
    .cfg_pattern(cfg_pattern), .z(z0), .o(o0), .match_cnt(cnt0));

  seq_match_det #(.W(2), .N(4), .CNT_W(8), .OVERLAP(0), .PATTERN_INIT(8'b00_01_10_11)) u_dut1 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_sym(in_sym), .cfg_load(cfg_load),
    .cfg_pattern(cfg_pattern), .z(z1), .o(o1), .match_cnt(cnt1));

  seq_match_det #(.W(2), .N(4), .CNT_W(2), .OVERLAP(1), .PATTERN_INIT(8'b00_01_10_11)) u_dut2 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_sym(in_sym), .cfg_load(cfg_load),
    .cfg_pattern(cfg_pattern), .z(z2), .o(o2), .match_cnt(cnt2));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    int         row;
    logic [2:0] z;
    logic [2:0] o;
    logic [7:0] c0;
    logic [7:0] c1;
    logic [1:0] c2;
  } exp_t;

  exp_t q[$];
  int   n_chk  = 0;
  int   n_fail = 0;
  int   row_n  = 0;

  task automatic chk(input string name, input int row, input logic [7:0] got, input logic [7:0] want);
    n_chk++;
    if (got !== want) begin
      n_fail++;
      $display("FAIL row %0d %s: got %h want %h", row, name, got, want);
    end
  endtask

  // Monitor: one expected entry per driven cycle, compared mid-cycle.
  always @(negedge clk) begin
    exp_t e;
    if (q.size() > 0) begin
      e = q.pop_front();
      chk("z",    e.row, {5'd0, z2, z1, z0}, {5'd0, e.z});
      chk("o",    e.row, {5'd0, o2, o1, o0}, {5'd0, e.o});
      chk("cnt0", e.row, cnt0, e.c0);
      chk("cnt1", e.row, cnt1, e.c1);
      chk("cnt2", e.row, {6'd0, cnt2}, {6'd0, e.c2});
    end
  end

  // One cycle of stimulus; ez/eo bit i belongs to u_dut<i>.
  task automatic step(input logic r, input logic pulse, input logic v, input logic [1:0] s,
                      input logic ld, input logic [7:0] pat, input logic [2:0] ez,
                      input logic [2:0] eo, input logic [7:0] e0, input logic [7:0] e1,
                      input logic [1:0] e2);
    exp_t e;
    @(posedge clk);
    #1;
    rst         = r;
    in_valid    = v;
    in_sym      = s;
    cfg_load    = ld;
    cfg_pattern = pat;
    if (pulse) begin
      rst = 1'b1;
      #1;
      rst = 1'b0;
    end
    row_n++;
    e.row = row_n; e.z = ez; e.o = eo; e.c0 = e0; e.c1 = e1; e.c2 = e2;
    q.push_back(e);
  endtask

  initial begin
    rst = 1'b1; in_valid = 1'b0; in_sym = 2'b00; cfg_load = 1'b0; cfg_pattern = 8'h00;

    //   rst pls v  sym    ld pat       z       o       c0 c1 c2
    step(1, 0, 0, 2'b00, 0, 8'h00, 3'b000, 3'b000, 0, 0, 0);
    // basic match 00,01,10,11
    step(0, 0, 1, 2'b00, 0, 8'h00, 3'b000, 3'b000, 0, 0, 0);
    step(0, 0, 1, 2'b01, 0, 8'h00, 3'b000, 3'b000, 0, 0, 0);
    step(0, 0, 1, 2'b10, 0, 8'h00, 3'b000, 3'b000, 0, 0, 0);
    step(0, 0, 1, 2'b11, 0, 8'h00, 3'b111, 3'b000, 0, 0, 0);
    step(0, 0, 0, 2'b00, 0, 8'h00, 3'b000, 3'b111, 1, 1, 1);
    // gapped pattern: 00, idle x3, 01, 10, idle, 11
    step(0, 0, 1, 2'b00, 0, 8'h00, 3'b000, 3'b000, 1, 1, 1);
    step(0, 0, 0, 2'b00, 0, 8'h00, 3'b000, 3'b000, 1, 1, 1);
    step(0, 0, 0, 2'b00, 0, 8'h00, 3'b000, 3'b000, 1, 1, 1);
    step(0, 0, 0, 2'b00, 0, 8'h00, 3'b000, 3'b000, 1, 1, 1);
    step(0, 0, 1, 2'b01, 0, 8'h00, 3'b000, 3'b000, 1, 1, 1);
    step(0, 0, 1, 2'b10, 0, 8'h00, 3'b000, 3'b000, 1, 1, 1);
    step(0, 0, 0, 2'b00, 0, 8'h00, 3'b000, 3'b000, 1, 1, 1);
    step(0, 0, 1, 2'b11, 0, 8'h00, 3'b111, 3'b000, 1, 1, 1);
    step(0, 0, 0, 2'b00, 0, 8'h00, 3'b000, 3'b111, 2, 2, 2);
    // partial 00,01,10 then async reset pulse while 11 is presented
    step(0, 0, 1, 2'b00, 0, 8'h00, 3'b000, 3'b000, 2, 2, 2);
    step(0, 0, 1, 2'b01, 0, 8'h00, 3'b000, 3'b000, 2, 2, 2);
    step(0, 0, 1, 2'b10, 0, 8'h00, 3'b000, 3'b000, 2, 2, 2);
    step(0, 1, 1, 2'b11, 0, 8'h00, 3'b000, 3'b000, 0, 0, 0);
    step(0, 0, 1, 2'b00, 0, 8'h00, 3'b000, 3'b000, 0, 0, 0);
    step(0, 0, 1, 2'b01, 0, 8'h00, 3'b000, 3'b000, 0, 0, 0);
    step(0, 0, 1, 2'b10, 0, 8'h00, 3'b000, 3'b000, 0, 0, 0);
    step(0, 0, 1, 2'b11, 0, 8'h00, 3'b111, 3'b000, 0, 0, 0);
    step(0, 0, 0, 2'b00, 0, 8'h00, 3'b000, 3'b111, 1, 1, 1);
    // reload colliding with a valid symbol, then match the new pattern
    step(0, 0, 1, 2'b00, 0, 8'h00, 3'b000, 3'b000, 1, 1, 1);
    step(0, 0, 1, 2'b01, 0, 8'h00, 3'b000, 3'b000, 1, 1, 1);
    step(0, 0, 1, 2'b10, 1, 8'hF0, 3'b000, 3'b000, 1, 1, 1);
    step(0, 0, 1, 2'b11, 0, 8'h00, 3'b000, 3'b000, 1, 1, 1);
    step(0, 0, 1, 2'b11, 0, 8'h00, 3'b000, 3'b000, 1, 1, 1);
    step(0, 0, 1, 2'b00, 0, 8'h00, 3'b000, 3'b000, 1, 1, 1);
    step(0, 0, 1, 2'b00, 0, 8'h00, 3'b111, 3'b000, 1, 1, 1);
    step(0, 0, 0, 2'b00, 0, 8'h00, 3'b000, 3'b111, 2, 2, 2);
    // fresh reset, load 01,01,01,01, then nine 01 symbols
    step(1, 0, 0, 2'b00, 0, 8'h00, 3'b000, 3'b000, 0, 0, 0);
    step(0, 0, 0, 2'b00, 1, 8'h55, 3'b000, 3'b000, 0, 0, 0);
    step(0, 0, 1, 2'b01, 0, 8'h00, 3'b000, 3'b000, 0, 0, 0);
    step(0, 0, 1, 2'b01, 0, 8'h00, 3'b000, 3'b000, 0, 0, 0);
    step(0, 0, 1, 2'b01, 0, 8'h00, 3'b000, 3'b000, 0, 0, 0);
    step(0, 0, 1, 2'b01, 0, 8'h00, 3'b111, 3'b000, 0, 0, 0);
    step(0, 0, 1, 2'b01, 0, 8'h00, 3'b101, 3'b111, 1, 1, 1);
    step(0, 0, 1, 2'b01, 0, 8'h00, 3'b101, 3'b101, 2, 1, 2);
    step(0, 0, 1, 2'b01, 0, 8'h00, 3'b101, 3'b101, 3, 1, 3);
    step(0, 0, 1, 2'b01, 0, 8'h00, 3'b111, 3'b101, 4, 1, 3);
    step(0, 0, 1, 2'b01, 0, 8'h00, 3'b101, 3'b111, 5, 2, 3);
    step(0, 0, 0, 2'b00, 0, 8'h00, 3'b000, 3'b101, 6, 2, 3);
    step(0, 0, 0, 2'b00, 0, 8'h00, 3'b000, 3'b000, 6, 2, 3);

    @(posedge clk);
    @(posedge clk);
    if (q.size() != 0) begin
      n_fail++;
      $display("FAIL drain: got %0d pending entries want 0", q.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
